// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: E-stage forwarding, load-use stall, branch flush,
// and a multi-cycle MUL/DIV interlock with a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic [STAT_W-1:0] StallCnt
);

  localparam int                CNT_W    = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((MD_LAT > 1) ? MD_LAT - 2 : 0);
  localparam logic              MD_EN    = (MD_LAT > 1);

  typedef enum logic {S_IDLE, S_BUSY} md_state_t;

  md_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_md_busy;
  logic [STAT_W-1:0] r_stall_cnt;

  logic w_lw_stall;
  logic w_md_stall;
  logic w_stall_f;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E))
      ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E))
      ForwardBE = 2'b01;
  end

  assign w_lw_stall = LoadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // The final BUSY cycle (cnt==0) releases the stall so the op leaves E on that edge.
  assign w_md_stall = ((r_state == S_IDLE) && MdStartE && MD_EN) ||
                      ((r_state == S_BUSY) && (r_cnt != '0));

  assign w_stall_f = w_md_stall | w_lw_stall;

  assign StallE   = w_md_stall;
  assign StallF   = w_stall_f;
  assign StallD   = w_stall_f;
  assign FlushE   = !w_md_stall && (w_lw_stall || PCSrcE);
  assign FlushD   = !w_md_stall && PCSrcE;
  assign MdBusy   = r_md_busy;
  assign StallCnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_md_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MdStartE && MD_EN) begin
            r_state   <= S_BUSY;
            r_cnt     <= CNT_INIT;
            r_md_busy <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state   <= S_IDLE;
            r_md_busy <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_md_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall_f && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed hazard scenarios plus randomized traffic
// checked against a cycle-level reference model (op age in E, stall counts).
module tb_hazard_unit_mc;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;
  logic [AW-1:0] RD_M, RD_W, RD_E, Rs1_E, Rs2_E, Rs1_D, Rs2_D;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, MdBusy;
  logic [15:0]   StallCnt;
  logic [1:0]    s_fa, s_fb;
  logic          s_sf, s_sd, s_se, s_fd, s_fe, s_busy;
  logic [2:0]    s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int            md_age;
  int            exp_sat;
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(AW), .MD_LAT(LAT), .STAT_W(16)) u_dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  hazard_unit_mc #(.REG_AW(AW), .MD_LAT(LAT), .STAT_W(3)) u_sat (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
    .StallE(s_se), .FlushD(s_fd), .FlushE(s_fe), .MdBusy(s_busy), .StallCnt(s_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'd2;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic ref_lw();
    return LoadE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
  endfunction

  // A multi-cycle op stalls E while its age is below LAT-1; a new op starts at age 0.
  function automatic logic ref_md();
    if (md_age == 0) return MdStartE && (LAT > 1);
    return md_age < LAT - 1;
  endfunction

  task automatic model_reset();
    md_age  = 0;
    exp_sat = 0;
    exp_q.delete();
    exp_q.push_back(32'd0);
  endtask

  task automatic model_update();
    logic        sf;
    logic [31:0] c;
    sf = ref_md() | ref_lw();
    c  = exp_q.pop_front();
    if (sf && c < 32'd65535) c++;
    exp_q.push_back(c);
    if (sf && exp_sat < 7) exp_sat++;
    if (md_age == 0) begin
      if (MdStartE && LAT > 1) md_age = 1;
    end else if (md_age == LAT - 1) begin
      md_age = 0;
    end else begin
      md_age++;
    end
  endtask

  task automatic check_outputs();
    logic md, lw;
    md = ref_md();
    lw = ref_lw();
    check_val("fwd_a",   ForwardAE, ref_fwd(Rs1_E));
    check_val("fwd_b",   ForwardBE, ref_fwd(Rs2_E));
    check_val("stall_f", StallF, md | lw);
    check_val("stall_d", StallD, md | lw);
    check_val("stall_e", StallE, md);
    check_val("flush_d", FlushD, !md && PCSrcE);
    check_val("flush_e", FlushE, !md && (lw || PCSrcE));
    check_val("md_busy", MdBusy, md_age != 0);
    check_val("stall_cnt", StallCnt, exp_q[0]);
    check_val("sat_cnt", s_cnt, exp_sat);
  endtask

  // Inputs are set just after a falling edge; check, clock once, advance the model.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MdStartE = 0;
    RD_M = 0; RD_W = 0; RD_E = 0; Rs1_E = 0; Rs2_E = 0; Rs1_D = 0; Rs2_D = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic md_sequence(input string tag);
    int stalls = 0, busys = 0, flushes = 0;
    MdStartE = 1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      stalls  += (StallE && StallF) ? 1 : 0;
      busys   += MdBusy ? 1 : 0;
      flushes += FlushE ? 1 : 0;
      step();
    end
    MdStartE = 0;
    check_val({tag, "_stalls"}, stalls, LAT - 1);
    check_val({tag, "_busy"}, busys, LAT - 1);
    check_val({tag, "_flush_e"}, flushes, 0);
    #1;
    check_val({tag, "_idle"}, MdBusy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    check_val("rst_fwd_a", ForwardAE, 0);
    check_val("rst_fwd_b", ForwardBE, 0);
    check_val("rst_stall", {StallF, StallD, StallE}, 0);
    check_val("rst_flush", {FlushD, FlushE}, 0);
    check_val("rst_busy", MdBusy, 0);
    check_val("rst_cnt", StallCnt, 0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Forwarding priority
    Rs1_E = 5; RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5;
    #1 check_val("fwd_m_wins", ForwardAE, 2'b10);
    step();
    RD_M = 0;
    #1 check_val("fwd_w_only", ForwardAE, 2'b01);
    step();
    RegWriteW = 0;
    #1 check_val("fwd_none", ForwardAE, 2'b00);
    step();
    clear_inputs();

    // Load-use
    LoadE = 1; RD_E = 7; Rs2_D = 7;
    #1 check_val("lw_stall", {StallF, StallD, FlushE}, 3'b111);
    step();
    LoadE = 0;
    #1 check_val("lw_cnt", StallCnt, 1);
    LoadE = 1; RD_E = 0;
    #1 check_val("lw_x0", StallF, 0);
    step();
    clear_inputs();

    md_sequence("md1");

    // Branch alone and branch under an MD stall
    PCSrcE = 1;
    #1 check_val("br_flush", {FlushD, FlushE, StallF}, 3'b110);
    step();
    MdStartE = 1;
    #1 check_val("br_md_flush", {FlushD, FlushE}, 2'b00);
    step();
    PCSrcE = 0;
    for (int i = 1; i < LAT; i++) step();
    MdStartE = 0;
    step();

    // Asynchronous reset in the middle of a BUSY sequence
    MdStartE = 1;
    step();
    step();
    #1 check_val("mid_busy", MdBusy, 1);
    MdStartE = 0;
    #1 rst = 1;
    #1;
    check_val("arst_busy", MdBusy, 0);
    check_val("arst_stall_e", StallE, 0);
    check_val("arst_cnt", StallCnt, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    md_sequence("md_after_rst");

    // Saturation of the 3-bit counter
    apply_reset();
    LoadE = 1; RD_E = 7; Rs2_D = 7;
    for (int i = 0; i < 10; i++) step();
    clear_inputs();
    #1;
    check_val("sat_hold7", s_cnt, 7);
    check_val("cnt16_10", StallCnt, 10);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      RD_M  = AW'($urandom_range(0, 7));
      RD_W  = AW'($urandom_range(0, 7));
      RD_E  = AW'($urandom_range(0, 7));
      Rs1_E = AW'($urandom_range(0, 7));
      Rs2_E = AW'($urandom_range(0, 7));
      Rs1_D = AW'($urandom_range(0, 7));
      Rs2_D = AW'($urandom_range(0, 7));
      LoadE    = ($urandom_range(0, 3) == 0);
      PCSrcE   = ($urandom_range(0, 7) == 0);
      MdStartE = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
